noc_vc_fifo: RTL and testbench
==============================

# noc_vc_fifo

Multi-channel (virtual-channel) input buffer for the NoC router port. It holds CHANNELS independent FIFOs of DEPTH entries each in one shared storage array. Each channel has its own occupancy counter, status flags, clear and error flags. Every accepted pop produces a registered credit-return pulse for upstream flow control. It replaces the single-channel port FIFO wherever a router input needs per-VC buffering.

## Interface
Parameters:
- WIDTH, 32, flit width in bits
- CHANNELS, 4, number of virtual channels; at least 1
- DEPTH, 8, entries per channel; power of two, at least 2
- THRESHOLD, DEPTH-1, occupancy at which almost_full asserts; range 1..DEPTH
- PUSH_WHEN_FULL_POP, 1, if 1, a push to a full channel is accepted when the same channel is popped in the same cycle

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- i_clear  in  CHANNELS  per-channel synchronous flush
- i_push  in  1  push request
- i_push_vc  in  $clog2(CHANNELS) (min 1)  target channel of the push
- i_data  in  WIDTH  push data
- i_pop  in  1  pop request
- i_pop_vc  in  $clog2(CHANNELS) (min 1)  channel to pop and to show on o_data
- o_data  out  WIDTH  head entry of channel i_pop_vc; 0 when that channel is empty
- o_empty / o_almost_full / o_full  out  CHANNELS  per-channel flags
- o_count  out  CHANNELS*$clog2(DEPTH+1)  packed per-channel occupancy
- o_credit_valid  out  1  one-cycle pulse per accepted pop
- o_credit_vc  out  $clog2(CHANNELS) (min 1)  channel of the returned credit
- o_overflow / o_underflow  out  CHANNELS  sticky error flags per channel

## Operation
- Storage address is {vc, pointer}: CHANNELS*DEPTH words. Storage is not reset.
- Each channel has a write pointer, a read pointer (log2 DEPTH bits, natural wrap DEPTH-1→0) and a counter (0..DEPTH).
- **Pop acceptance:** a pop is accepted when i_pop is high and channel i_pop_vc is not empty.
- **Push acceptance:**
  - accepted when i_push is high and channel i_push_vc is not full, or
  - when the channel is full, PUSH_WHEN_FULL_POP=1, and a pop is accepted on the same channel in the same cycle.
- **Simultaneous push and pop, same channel:** count unchanged, both pointers advance.
- **Simultaneous push and pop, different channels:** the two channels update independently.
- **Rejected push** (target full, exception not met): no state change; o_overflow[vc] is set.
- **Rejected pop** (target empty): o_underflow[vc] is set and no credit is issued.
- **Push to empty channel with pop of that channel in the same cycle:** the pop is rejected (underflow). There is no bypass.
- **Flags** are combinational from the registered count:
  - empty = (count==0)
  - almost_full = (count>=THRESHOLD)
  - full = (count==DEPTH)
- **o_data:** combinational read at {i_pop_vc, rd_ptr[i_pop_vc]}, forced to 0 when that channel is empty.
- **i_clear[c]:**
  - at the next edge, zeroes counter c, both pointers of c, o_overflow[c] and o_underflow[c];
  - overrides a push or pop to channel c in the same cycle: no credit, no error set;
  - other channels are unaffected.
- **rst:** all counters, pointers, error flags, o_credit_valid and o_credit_vc become 0, so o_empty is all ones and o_data is 0. Reset asserted mid-traffic discards contents with no credits returned.

## Timing
- Write-to-visible latency: data pushed at edge N appears on o_data (channel selected, previously empty) after edge N; count and flags also update at edge N.
- Pop is consumed at the edge. o_data shows the next entry combinationally after that edge.
- Credit: an accepted pop at edge N drives o_credit_valid=1 and o_credit_vc=vc for the cycle following edge N. Back-to-back pops give back-to-back credits.
- Error flags set at the edge of the offending request. They stay set until rst or i_clear of that channel.

## Structure
- Package noc_vc_fifo_pkg:
  - vc_id_t
  - a status-flag struct (empty, almost_full, full)
  - a function mapping count to the flag struct
- Sub-module noc_vc_fifo_chan_ctrl: per-channel counter, pointers, flags and error bits, instantiated CHANNELS times in a generate loop.
- The top level holds the storage array, the o_data mux and the credit register.

## Test plan
All scenarios use WIDTH=8, CHANNELS=4, DEPTH=4, THRESHOLD=3.
- Reset, then idle → o_empty=4'b1111, o_full=0, o_data=0, o_credit_valid=0, all counts 0.
- Push 0x11, 0x22, 0x33, 0x44 to vc2 → after the third push o_almost_full[2]=1; after the fourth o_full[2]=1. Pop vc2 four times → o_data reads 0x11, 0x22, 0x33, 0x44; credits on vc2 one cycle after each pop.
- vc1 full: push 0x55 with no pop → rejected, o_overflow[1]=1, count stays 4. Push 0x66 with a concurrent pop of vc1 → accepted, count 4, 0x66 read out last.
- Interleave: push vc0=0xA0 and pop vc3 (empty) in the same cycle → vc0 count 1, o_underflow[3]=1, no credit.
- Fill vc0 with 3 entries and vc1 with 2. Assert i_clear=4'b0001 with a concurrent pop of vc0 → vc0 count 0, no credit; vc1 count 2 with data intact.
- Push 6 entries into vc3 with a pop each cycle after the first → o_data order preserved across pointer wrap 3→0; count never exceeds 1.

Source files
------------

// File: rtl/noc_vc_fifo_pkg.sv
// noc_vc_fifo_pkg: shared types and helpers for the virtual-channel input buffer
package noc_vc_fifo_pkg;

    typedef logic [7:0] vc_id_t;

    typedef struct packed {
        logic empty;
        logic almost_full;
        logic full;
    } vc_flags_t;

    function automatic vc_flags_t count_to_flags(input int count, input int threshold, input int depth);
        vc_flags_t f;
        f.empty       = count == 0;
        f.almost_full = count >= threshold;
        f.full        = count == depth;
        return f;
    endfunction

endpackage

// File: rtl/noc_vc_fifo_chan_ctrl.sv
// noc_vc_fifo_chan_ctrl: occupancy, pointers, flags and sticky errors of one virtual channel
module noc_vc_fifo_chan_ctrl
    import noc_vc_fifo_pkg::*;
#(
    parameter int DEPTH              = 8,
    parameter int THRESHOLD          = DEPTH - 1,
    parameter int PUSH_WHEN_FULL_POP = 1,
    localparam int PW                = $clog2(DEPTH),
    localparam int CW                = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic          pop_i,
    output logic          push_ok_o,
    output logic          pop_ok_o,
    output logic [PW-1:0] wr_ptr_o,
    output logic [PW-1:0] rd_ptr_o,
    output logic [CW-1:0] count_o,
    output vc_flags_t     flags_o,
    output logic          overflow_o,
    output logic          underflow_o
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d, underflow_q, underflow_d;

    assign flags_o     = count_to_flags(int'(count_q), THRESHOLD, DEPTH);
    assign pop_ok_o    = pop_i && !clear_i && !flags_o.empty;
    assign push_ok_o   = push_i && !clear_i && (!flags_o.full || (PUSH_WHEN_FULL_POP != 0 && pop_ok_o));
    assign wr_ptr_o    = wr_ptr_q;
    assign rd_ptr_o    = rd_ptr_q;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

    // next state; a clear wins over any request to this channel and drops its errors
    always_comb begin
        wr_ptr_d    = clear_i ? '0 : wr_ptr_q + PW'(push_ok_o);
        rd_ptr_d    = clear_i ? '0 : rd_ptr_q + PW'(pop_ok_o);
        count_d     = clear_i ? '0 : count_q + CW'(push_ok_o) - CW'(pop_ok_o);
        overflow_d  = !clear_i && (overflow_q || (push_i && !push_ok_o));
        underflow_d = !clear_i && (underflow_q || (pop_i && flags_o.empty));
    end

    // channel state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: rtl/noc_vc_fifo.sv
// noc_vc_fifo: per-VC input buffer sharing one storage array, with registered credit return
module noc_vc_fifo
    import noc_vc_fifo_pkg::*;
#(
    parameter int WIDTH              = 32,
    parameter int CHANNELS           = 4,
    parameter int DEPTH              = 8,
    parameter int THRESHOLD          = DEPTH - 1,
    parameter int PUSH_WHEN_FULL_POP = 1,
    localparam int VW                = CHANNELS > 1 ? $clog2(CHANNELS) : 1,
    localparam int CW                = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CHANNELS-1:0]    i_clear,
    input  logic                   i_push,
    input  logic [VW-1:0]          i_push_vc,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    input  logic [VW-1:0]          i_pop_vc,
    output logic [WIDTH-1:0]       o_data,
    output logic [CHANNELS-1:0]    o_empty,
    output logic [CHANNELS-1:0]    o_almost_full,
    output logic [CHANNELS-1:0]    o_full,
    output logic [CHANNELS*CW-1:0] o_count,
    output logic                   o_credit_valid,
    output logic [VW-1:0]          o_credit_vc,
    output logic [CHANNELS-1:0]    o_overflow,
    output logic [CHANNELS-1:0]    o_underflow
);

    localparam int NV = 1 << VW;
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [NV*DEPTH];
    logic [PW-1:0]    wr_ptr [NV];
    logic [PW-1:0]    rd_ptr [NV];
    logic [NV-1:0]    push_ok, pop_ok, empty_all;
    logic             credit_valid_q;
    logic [VW-1:0]    credit_vc_q;

    // unused channel ids (CHANNELS not a power of two) read as permanently empty
    for (genvar c = 0; c < NV; c++) begin : g_vc
        if (c < CHANNELS) begin : g_ch
            vc_flags_t     flags;
            logic [CW-1:0] count;
            noc_vc_fifo_chan_ctrl #(
                .DEPTH(DEPTH),
                .THRESHOLD(THRESHOLD),
                .PUSH_WHEN_FULL_POP(PUSH_WHEN_FULL_POP)
            ) u_ctrl (
                .clk(clk),
                .rst(rst),
                .clear_i(i_clear[c]),
                .push_i(i_push && i_push_vc == VW'(c)),
                .pop_i(i_pop && i_pop_vc == VW'(c)),
                .push_ok_o(push_ok[c]),
                .pop_ok_o(pop_ok[c]),
                .wr_ptr_o(wr_ptr[c]),
                .rd_ptr_o(rd_ptr[c]),
                .count_o(count),
                .flags_o(flags),
                .overflow_o(o_overflow[c]),
                .underflow_o(o_underflow[c])
            );
            assign empty_all[c]       = flags.empty;
            assign o_empty[c]         = flags.empty;
            assign o_almost_full[c]   = flags.almost_full;
            assign o_full[c]          = flags.full;
            assign o_count[c*CW +: CW] = count;
        end else begin : g_pad
            assign push_ok[c]   = 1'b0;
            assign pop_ok[c]    = 1'b0;
            assign wr_ptr[c]    = '0;
            assign rd_ptr[c]    = '0;
            assign empty_all[c] = 1'b1;
        end
    end

    assign o_data         = empty_all[i_pop_vc] ? '0 : mem_q[{i_pop_vc, rd_ptr[i_pop_vc]}];
    assign o_credit_valid = credit_valid_q;
    assign o_credit_vc    = credit_vc_q;

    // shared storage written at {vc, wr_ptr}; contents are not reset
    always_ff @(posedge clk) begin
        if (|push_ok) mem_q[{i_push_vc, wr_ptr[i_push_vc]}] <= i_data;
    end

    // one credit per accepted pop, presented the cycle after the pop
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_valid_q <= 1'b0;
            credit_vc_q    <= '0;
        end else begin
            credit_valid_q <= |pop_ok;
            if (|pop_ok) credit_vc_q <= i_pop_vc;
        end
    end

endmodule

// File: tb/tb_noc_vc_fifo.sv
// tb_noc_vc_fifo: vector table, directed corner cases and random traffic against a queue model
module tb_noc_vc_fifo;

    localparam int WIDTH = 8, CHANNELS = 4, DEPTH = 4, THRESHOLD = 3, PWFP = 1;

    logic        clk = 1'b0, rst = 1'b1;
    logic [3:0]  i_clear = '0;
    logic        i_push = 1'b0, i_pop = 1'b0;
    logic [1:0]  i_push_vc = '0, i_pop_vc = '0;
    logic [7:0]  i_data = '0;
    logic [7:0]  o_data;
    logic [3:0]  o_empty, o_almost_full, o_full, o_overflow, o_underflow;
    logic [11:0] o_count;
    logic        o_credit_valid;
    logic [1:0]  o_credit_vc;

    int n_cmp = 0, n_err = 0;

    logic [7:0] mq [CHANNELS][$];
    logic [3:0] m_ovf = '0, m_unf = '0;
    logic       m_cv = 1'b0;
    logic [1:0] m_cvc = '0;

    typedef struct {
        logic        ps;
        logic [1:0]  pv;
        logic [7:0]  d;
        logic        pp;
        logic [1:0]  ov;
        logic [7:0]  e_data;
        logic        e_cv;
        logic [11:0] e_cnt;
        logic [3:0]  e_af;
        logic [3:0]  e_full;
    } vec_t;

    vec_t tbl [9];

    noc_vc_fifo #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH),
        .THRESHOLD(THRESHOLD), .PUSH_WHEN_FULL_POP(PWFP)
    ) dut (
        .clk(clk), .rst(rst), .i_clear(i_clear),
        .i_push(i_push), .i_push_vc(i_push_vc), .i_data(i_data),
        .i_pop(i_pop), .i_pop_vc(i_pop_vc), .o_data(o_data),
        .o_empty(o_empty), .o_almost_full(o_almost_full), .o_full(o_full),
        .o_count(o_count), .o_credit_valid(o_credit_valid), .o_credit_vc(o_credit_vc),
        .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // behavioural model: one queue per channel, updated with the inputs seen at the edge
    task automatic model_edge();
        bit pa, qa;
        m_cv = 1'b0;
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) mq[c].delete();
            m_ovf = '0;
            m_unf = '0;
            m_cvc = '0;
            return;
        end
        pa = i_pop && !i_clear[i_pop_vc] && mq[i_pop_vc].size() != 0;
        qa = i_push && !i_clear[i_push_vc] &&
             (mq[i_push_vc].size() < DEPTH || (PWFP != 0 && pa && i_pop_vc == i_push_vc));
        if (i_push && !i_clear[i_push_vc] && !qa) m_ovf[i_push_vc] = 1'b1;
        if (i_pop && !i_clear[i_pop_vc] && mq[i_pop_vc].size() == 0) m_unf[i_pop_vc] = 1'b1;
        if (pa) begin
            void'(mq[i_pop_vc].pop_front());
            m_cv  = 1'b1;
            m_cvc = i_pop_vc;
        end
        if (qa) mq[i_push_vc].push_back(i_data);
        for (int c = 0; c < CHANNELS; c++)
            if (i_clear[c]) begin
                mq[c].delete();
                m_ovf[c] = 1'b0;
                m_unf[c] = 1'b0;
            end
    endtask

    task automatic check_model();
        logic [3:0]  ee, ea, ef;
        logic [11:0] ec;
        logic [7:0]  ed;
        for (int c = 0; c < CHANNELS; c++) begin
            ee[c] = mq[c].size() == 0;
            ea[c] = mq[c].size() >= THRESHOLD;
            ef[c] = mq[c].size() == DEPTH;
            ec[c*3 +: 3] = 3'(mq[c].size());
        end
        ed = mq[i_pop_vc].size() == 0 ? 8'h00 : mq[i_pop_vc][0];
        chk("data", 32'(o_data), 32'(ed));
        chk("empty", 32'(o_empty), 32'(ee));
        chk("almost_full", 32'(o_almost_full), 32'(ea));
        chk("full", 32'(o_full), 32'(ef));
        chk("count", 32'(o_count), 32'(ec));
        chk("credit_valid", 32'(o_credit_valid), 32'(m_cv));
        if (m_cv) chk("credit_vc", 32'(o_credit_vc), 32'(m_cvc));
        chk("overflow", 32'(o_overflow), 32'(m_ovf));
        chk("underflow", 32'(o_underflow), 32'(m_unf));
    endtask

    task automatic drive(input logic [3:0] clr, input logic ps, input logic [1:0] pv,
                         input logic [7:0] d, input logic pp, input logic [1:0] ov);
        i_clear   = clr;
        i_push    = ps;
        i_push_vc = pv;
        i_data    = d;
        i_pop     = pp;
        i_pop_vc  = ov;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        tbl[0] = '{1'b1, 2'd2, 8'h11, 1'b0, 2'd2, 8'h11, 1'b0, 12'h040, 4'h0, 4'h0};
        tbl[1] = '{1'b1, 2'd2, 8'h22, 1'b0, 2'd2, 8'h11, 1'b0, 12'h080, 4'h0, 4'h0};
        tbl[2] = '{1'b1, 2'd2, 8'h33, 1'b0, 2'd2, 8'h11, 1'b0, 12'h0C0, 4'h4, 4'h0};
        tbl[3] = '{1'b1, 2'd2, 8'h44, 1'b0, 2'd2, 8'h11, 1'b0, 12'h100, 4'h4, 4'h4};
        tbl[4] = '{1'b0, 2'd2, 8'h00, 1'b1, 2'd2, 8'h22, 1'b1, 12'h0C0, 4'h4, 4'h0};
        tbl[5] = '{1'b0, 2'd2, 8'h00, 1'b1, 2'd2, 8'h33, 1'b1, 12'h080, 4'h0, 4'h0};
        tbl[6] = '{1'b0, 2'd2, 8'h00, 1'b1, 2'd2, 8'h44, 1'b1, 12'h040, 4'h0, 4'h0};
        tbl[7] = '{1'b0, 2'd2, 8'h00, 1'b1, 2'd2, 8'h00, 1'b1, 12'h000, 4'h0, 4'h0};
        tbl[8] = '{1'b0, 2'd2, 8'h00, 1'b0, 2'd2, 8'h00, 1'b0, 12'h000, 4'h0, 4'h0};

        rst = 1'b1;
        drive(4'h0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        drive(4'h0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        rst = 1'b0;
        drive(4'h0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        chk("rst_empty", 32'(o_empty), 32'hF);
        chk("rst_full", 32'(o_full), 32'h0);
        chk("rst_data", 32'(o_data), 32'h0);
        chk("rst_credit", 32'(o_credit_valid), 32'h0);
        chk("rst_credit_vc", 32'(o_credit_vc), 32'h0);
        chk("rst_count", 32'(o_count), 32'h0);

        for (int i = 0; i < 9; i++) begin
            drive(4'h0, tbl[i].ps, tbl[i].pv, tbl[i].d, tbl[i].pp, tbl[i].ov);
            chk("tbl_data", 32'(o_data), 32'(tbl[i].e_data));
            chk("tbl_credit", 32'(o_credit_valid), 32'(tbl[i].e_cv));
            if (tbl[i].e_cv) chk("tbl_credit_vc", 32'(o_credit_vc), 32'd2);
            chk("tbl_count", 32'(o_count), 32'(tbl[i].e_cnt));
            chk("tbl_af", 32'(o_almost_full), 32'(tbl[i].e_af));
            chk("tbl_full", 32'(o_full), 32'(tbl[i].e_full));
        end

        for (int k = 0; k < 4; k++) drive(4'h0, 1'b1, 2'd1, 8'(k + 1), 1'b0, 2'd1);
        drive(4'h0, 1'b1, 2'd1, 8'h55, 1'b0, 2'd1);
        chk("ovf_flag", 32'(o_overflow[1]), 32'd1);
        chk("ovf_count", 32'(o_count[5:3]), 32'd4);
        drive(4'h0, 1'b1, 2'd1, 8'h66, 1'b1, 2'd1);
        chk("pwfp_count", 32'(o_count[5:3]), 32'd4);
        chk("pwfp_credit", 32'(o_credit_valid), 32'd1);
        for (int k = 0; k < 3; k++) drive(4'h0, 1'b0, 2'd1, 8'h00, 1'b1, 2'd1);
        chk("pwfp_last", 32'(o_data), 32'h66);
        drive(4'h0, 1'b0, 2'd1, 8'h00, 1'b1, 2'd1);
        chk("pwfp_drained", 32'(o_count[5:3]), 32'd0);

        drive(4'h0, 1'b1, 2'd0, 8'hA0, 1'b1, 2'd3);
        chk("intl_count0", 32'(o_count[2:0]), 32'd1);
        chk("intl_unf3", 32'(o_underflow[3]), 32'd1);
        chk("intl_no_credit", 32'(o_credit_valid), 32'd0);

        drive(4'h0, 1'b1, 2'd0, 8'hB0, 1'b0, 2'd0);
        drive(4'h0, 1'b1, 2'd0, 8'hB1, 1'b0, 2'd0);
        drive(4'h0, 1'b1, 2'd1, 8'hC1, 1'b0, 2'd1);
        drive(4'h0, 1'b1, 2'd1, 8'hC2, 1'b0, 2'd1);
        drive(4'b0001, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
        chk("clr_count0", 32'(o_count[2:0]), 32'd0);
        chk("clr_no_credit", 32'(o_credit_valid), 32'd0);
        chk("clr_count1", 32'(o_count[5:3]), 32'd2);
        chk("clr_ovf1_kept", 32'(o_overflow[1]), 32'd1);
        drive(4'h0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd1);
        chk("clr_data1", 32'(o_data), 32'hC1);
        drive(4'h0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
        drive(4'h0, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1);

        drive(4'h0, 1'b1, 2'd3, 8'hD0, 1'b0, 2'd3);
        for (int k = 1; k < 6; k++) begin
            drive(4'h0, 1'b1, 2'd3, 8'(8'hD0 + k), 1'b1, 2'd3);
            chk("wrap_count", 32'(o_count[11:9]), 32'd1);
            chk("wrap_data", 32'(o_data), 32'(8'hD0 + k));
        end
        drive(4'h0, 1'b0, 2'd3, 8'h00, 1'b1, 2'd3);

        for (int i = 0; i < 400; i++) begin
            rst = (i == 200 || i == 201);
            drive($urandom_range(0, 15) == 0 ? 4'($urandom) : 4'h0,
                  1'($urandom_range(0, 9) < 6), 2'($urandom), 8'($urandom),
                  1'($urandom_range(0, 9) < 5), 2'($urandom));
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
